// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Control bundle between the Mini SRC sequencer and its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if;
    logic       run;
    logic [4:0] ir_opcode;
    logic       incPC, e_MAR, e_PC, e_IR, e_Y, e_Z, e_MDR, MDR_read, ram_read;
    logic       Gra, Grb, e_Rin, e_Rout, BAout, imm_sel;
    logic       link_we;
    logic [3:0] link_idx;
    logic [3:0] ALU_op;
    logic [4:0] BusDataSelect;
    logic       halted, illegal;
    logic [4:0] state_o;

    modport master (
        input  run, ir_opcode,
        output incPC, e_MAR, e_PC, e_IR, e_Y, e_Z, e_MDR, MDR_read, ram_read,
        output Gra, Grb, e_Rin, e_Rout, BAout, imm_sel, link_we, link_idx,
        output ALU_op, BusDataSelect, halted, illegal, state_o
    );

    modport slave (
        output run, ir_opcode,
        input  incPC, e_MAR, e_PC, e_IR, e_Y, e_Z, e_MDR, MDR_read, ram_read,
        input  Gra, Grb, e_Rin, e_Rout, BAout, imm_sel, link_we, link_idx,
        input  ALU_op, BusDataSelect, halted, illegal, state_o
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Hardwired Moore control unit sequencing fetch/decode/execute.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned LINK_REG = 8,
    parameter logic [4:0]  OP_LD    = 5'b00000,
    parameter logic [4:0]  OP_LDI   = 5'b00001,
    parameter logic [4:0]  OP_JR    = 5'b10100,
    parameter logic [4:0]  OP_JAL   = 5'b10101,
    parameter logic [4:0]  OP_HALT  = 5'b11011
) (
    input  wire logic           clock,
    input  wire logic           clear,
    instr_sequencer_if.master   bus
);
    localparam int         c_CNT_W   = $clog2(MEM_WAIT + 1);
    localparam logic [3:0] c_ALU_ADD = 4'b0011;
    localparam logic [4:0] c_BS_ZLOW = 5'b10011;
    localparam logic [4:0] c_BS_PC   = 5'b10100;
    localparam logic [4:0] c_BS_MDR  = 5'b10101;

    typedef enum logic [4:0] {
        S_IDLE = 5'd0,  S_T0   = 5'd1,  S_T1  = 5'd2,  S_T2 = 5'd3,
        S_T3   = 5'd4,  S_DEC  = 5'd5,  S_A1  = 5'd6,  S_A2 = 5'd7,
        S_A3   = 5'd8,  S_M1   = 5'd9,  S_M2  = 5'd10, S_M3 = 5'd11,
        S_J1   = 5'd12, S_L1   = 5'd13, S_L2  = 5'd14, S_HALT = 5'd15,
        S_ILL  = 5'd16
    } state_t;

    state_t               r_state, w_next;
    logic [c_CNT_W-1:0]   r_wait, w_wait_next;
    logic                 r_is_ld, w_is_ld_next;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_is_ld <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            r_is_ld <= w_is_ld_next;
        end
    end

    assign bus.link_idx = 4'(LINK_REG);
    assign bus.state_o  = r_state;

    always_comb begin
        w_next            = r_state;
        w_wait_next       = r_wait;
        w_is_ld_next      = r_is_ld;
        bus.incPC         = 1'b0;
        bus.e_MAR         = 1'b0;
        bus.e_PC          = 1'b0;
        bus.e_IR          = 1'b0;
        bus.e_Y           = 1'b0;
        bus.e_Z           = 1'b0;
        bus.e_MDR         = 1'b0;
        bus.MDR_read      = 1'b0;
        bus.ram_read      = 1'b0;
        bus.Gra           = 1'b0;
        bus.Grb           = 1'b0;
        bus.e_Rin         = 1'b0;
        bus.e_Rout        = 1'b0;
        bus.BAout         = 1'b0;
        bus.imm_sel       = 1'b0;
        bus.link_we       = 1'b0;
        bus.ALU_op        = 4'b0000;
        bus.BusDataSelect = 5'b00000;
        bus.halted        = 1'b0;
        bus.illegal       = 1'b0;

        case (r_state)
            S_IDLE: if (bus.run) w_next = S_T0;
            S_T0: begin
                bus.BusDataSelect = c_BS_PC;
                bus.e_MAR         = 1'b1;
                bus.incPC         = 1'b1;
                w_wait_next       = c_CNT_W'(MEM_WAIT);
                w_next            = S_T1;
            end
            // The counter is reloaded on entry, so T1 and M1 each last MEM_WAIT cycles.
            S_T1, S_M1: begin
                bus.ram_read = 1'b1;
                if (r_wait > c_CNT_W'(1)) w_wait_next = r_wait - c_CNT_W'(1);
                else                      w_next      = (r_state == S_T1) ? S_T2 : S_M2;
            end
            S_T2, S_M2: begin
                bus.MDR_read = 1'b1;
                bus.e_MDR    = 1'b1;
                w_next       = (r_state == S_T2) ? S_T3 : S_M3;
            end
            S_T3: begin
                bus.BusDataSelect = c_BS_MDR;
                bus.e_IR          = 1'b1;
                w_next            = S_DEC;
            end
            S_DEC: begin
                w_is_ld_next = (bus.ir_opcode == OP_LD);
                if (bus.ir_opcode == OP_LD || bus.ir_opcode == OP_LDI) w_next = S_A1;
                else if (bus.ir_opcode == OP_JR)                       w_next = S_J1;
                else if (bus.ir_opcode == OP_JAL)                      w_next = S_L1;
                else if (bus.ir_opcode == OP_HALT)                     w_next = S_HALT;
                else                                                   w_next = S_ILL;
            end
            S_A1: begin
                bus.Grb   = 1'b1;
                bus.BAout = 1'b1;
                bus.e_Y   = 1'b1;
                w_next    = S_A2;
            end
            S_A2: begin
                bus.imm_sel = 1'b1;
                bus.ALU_op  = c_ALU_ADD;
                bus.e_Z     = 1'b1;
                w_next      = S_A3;
            end
            S_A3: begin
                bus.BusDataSelect = c_BS_ZLOW;
                if (r_is_ld) begin
                    bus.e_MAR   = 1'b1;
                    w_wait_next = c_CNT_W'(MEM_WAIT);
                    w_next      = S_M1;
                end else begin
                    bus.Gra   = 1'b1;
                    bus.e_Rin = 1'b1;
                    w_next    = S_T0;
                end
            end
            S_M3: begin
                bus.BusDataSelect = c_BS_MDR;
                bus.Gra           = 1'b1;
                bus.e_Rin         = 1'b1;
                w_next            = S_T0;
            end
            // L1 writes the link before L2 reads Ra, so jal through LINK_REG jumps to the link.
            S_L1: begin
                bus.BusDataSelect = c_BS_PC;
                bus.link_we       = 1'b1;
                w_next            = S_L2;
            end
            S_J1, S_L2: begin
                bus.Gra    = 1'b1;
                bus.e_Rout = 1'b1;
                bus.e_PC   = 1'b1;
                w_next     = S_T0;
            end
            S_HALT: bus.halted  = 1'b1;
            S_ILL:  bus.illegal = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end
endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Hardwired Moore control unit for the Mini SRC datapath.
- Issues the register-enable, bus-select, RAM and ALU control vector, one state per clock.
- Covers the fetch/decode/execute sequence for ld, ldi, jr, jal and halt, which benches currently drive by hand.
- Sits between the IR opcode field and the datapath control ports; adds configurable RAM wait states, jal linking, halt and illegal-opcode trapping.

Parameters:
MEM_WAIT, 1, RAM read latency in cycles (>=1); number of T1 wait states
LINK_REG, 8, register index written with return PC by jal
OP_LD, 5'b00000, ld opcode
OP_LDI, 5'b00001, ldi opcode
OP_JR, 5'b10100, jr opcode
OP_JAL, 5'b10101, jal opcode
OP_HALT, 5'b11011, halt opcode

Ports:
clock  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
run  in  1  when 1 in IDLE, begin fetch
ir_opcode  in  5  IR[31:27] from datapath
incPC, e_MAR, e_PC, e_IR, e_Y, e_Z, e_MDR, MDR_read, ram_read  out  1 each  datapath enables
Gra, Grb, e_Rin, e_Rout, BAout, imm_sel  out  1 each  select/encode controls
link_we  out  1  write bus into R[LINK_REG]
link_idx  out  4  constant LINK_REG
ALU_op  out  4  ALU operation (4'b0011 = ADD)
BusDataSelect  out  5  bus source (R0=00000, Zlow=10011, PC=10100, MDR=10101)
halted  out  1  sticky, set in HALT
illegal  out  1  sticky, set on unsupported opcode
state_o  out  5  current state code for debug

Behaviour:
- Reset: clock and clear are the only timing inputs; reset is synchronous, active-high. clear=1 at a rising edge forces state IDLE and halted=illegal=0, including mid-instruction. Every control output is 0 in IDLE.
- Moore outputs: all controls decode combinationally from the registered state only. Any control not listed for a state is 0. ALU_op defaults to 0.
- IDLE: run=1 -> T0, else stay.
- T0: BusDataSelect=PC, e_MAR, incPC -> T1.
- T1: ram_read; wait counter runs MEM_WAIT cycles, then -> T2.
- T2: MDR_read, e_MDR -> T3.
- T3: BusDataSelect=MDR, e_IR -> DEC.
- DEC: no outputs; samples ir_opcode (IR now valid) and branches:
  - ld/ldi -> A1
  - jr -> J1
  - jal -> L1
  - halt -> HALT
  - other -> ILL
- Fetch length is 4+MEM_WAIT cycles from T0 to DEC inclusive.
- A1: Grb, BAout, e_Y -> A2.
- A2: imm_sel, ALU_op=0011, e_Z -> A3.
- A3 (ldi): BusDataSelect=Zlow, Gra, e_Rin -> T0.
- A3 (ld): BusDataSelect=Zlow, e_MAR -> M1.
- M1: ram_read for MEM_WAIT cycles -> M2.
- M2: MDR_read, e_MDR -> M3.
- M3: BusDataSelect=MDR, Gra, e_Rin -> T0.
- J1: Gra, e_Rout, e_PC -> T0. PC loads Ra.
- L1: BusDataSelect=PC, link_we -> L2. Saves the already-incremented PC.
- L2: Gra, e_Rout, e_PC -> T0.
- L1/L2 when Ra==LINK_REG: link written first, then PC loads the new link value. This ordering is required, not an error.
- HALT: halted=1, stay until clear; run ignored.
- ILL: illegal=1, stay until clear.
- Sequencing: run only matters in IDLE. After the first start the unit free-runs back to T0 until halt, illegal or clear.
- Mutual exclusion: e_PC and incPC never both 1. At most one of Zlow/PC/MDR/e_Rout drives the bus per state.
- Wait counter: width clog2(MEM_WAIT+1). Reloads on entry to T1/M1 and never wraps.

Test Plan:
- Reset mid-ld: run=1, assert clear in M1 -> next cycle state=IDLE, all outputs 0, halted=illegal=0.
- ldi, MEM_WAIT=1:
  - Fetch takes 5 cycles T0..DEC; A1..A3 follow.
  - A3 shows BusDataSelect=10011, Gra=e_Rin=1.
  - Back in T0 at cycle 8; datapath R2=0x78.
- ld, MEM_WAIT=3:
  - T1 and M1 each hold ram_read exactly 3 cycles.
  - Instruction totals 7+3+5 = 15 cycles.
  - Ra gets memory word.
- jal R5 at PC=1, LINK_REG=8, R5=0x20:
  - L1 gives link_we with PC=2 on bus; R8=2.
  - L2 gives e_PC; PC=0x20; next T0 drives 0x20.
- jr, then halt opcode:
  - jr sets PC=Ra.
  - Next DEC sees 11011 -> HALT; halted=1 persists 20 cycles with run toggling.
- Opcode 5'b01111 -> ILL, illegal=1, no e_Rin/e_PC/ram_read after DEC; clear then run restarts fetch from T0.
